// File: rtl/sccb_bus_sniffer_if.sv
// Decoded-event stream between the SCCB sniffer and its consumer (ILA/AXI reader).
interface sccb_bus_sniffer_if;
  logic [10:0] m_data;
  logic        m_valid;
  logic        m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/sccb_bus_sniffer.sv
// Passive SCCB/I2C monitor: synchronise and filter SCL/SDA, decode START/STOP/bytes/ACK,
// and queue {kind, ack_n, byte} events in a first-word-fall-through FIFO.
module sccb_bus_sniffer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SHIFT_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          scl_i,
  input  logic                          sda_i,
  sccb_bus_sniffer_if.master            ev,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [SHIFT_W-1:0]            last_word,
  output logic                          bus_busy,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          clr_err
);

  localparam int unsigned FCW = $clog2(FILT_LEN + 1);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;

  typedef enum logic {IDLE, RECV} state_t;

  // ---------------- synchroniser + glitch filter ----------------
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [FCW-1:0]         scl_fcnt_q, scl_fcnt_d, sda_fcnt_q, sda_fcnt_d;
  logic                   scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
  logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic                   rise_q, rise_d, fall_q, fall_d;
  logic                   start_q, start_d, stop_q, stop_d;
  logic                   bit_q, bit_d;
  logic [SHIFT_W-1:0]     last_word_q, last_word_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};

    scl_filt_d = scl_filt_q;
    scl_fcnt_d = '0;
    if (scl_sync_q[SYNC_STAGES-1] != scl_filt_q) begin
      if (scl_fcnt_q == FCW'(FILT_LEN - 1)) scl_filt_d = ~scl_filt_q;
      else                                  scl_fcnt_d = scl_fcnt_q + FCW'(1);
    end

    sda_filt_d = sda_filt_q;
    sda_fcnt_d = '0;
    if (sda_sync_q[SYNC_STAGES-1] != sda_filt_q) begin
      if (sda_fcnt_q == FCW'(FILT_LEN - 1)) sda_filt_d = ~sda_filt_q;
      else                                  sda_fcnt_d = sda_fcnt_q + FCW'(1);
    end

    // SCL must be high on both sides of an SDA edge so simultaneous edges never look like START/STOP
    scl_prev_d = scl_filt_q;
    sda_prev_d = sda_filt_q;
    rise_d     = scl_filt_q & ~scl_prev_q;
    fall_d     = ~scl_filt_q & scl_prev_q;
    start_d    = ~sda_filt_q & sda_prev_q & scl_filt_q & scl_prev_q;
    stop_d     = sda_filt_q & ~sda_prev_q & scl_filt_q & scl_prev_q;
    bit_d      = sda_filt_q;

    last_word_d = last_word_q;
    if (rise_q) last_word_d = {last_word_q[SHIFT_W-2:0], bit_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_fcnt_q  <= '0;
      sda_fcnt_q  <= '0;
      scl_filt_q  <= 1'b1;
      sda_filt_q  <= 1'b1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      bit_q       <= 1'b0;
      last_word_q <= '0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_fcnt_q  <= scl_fcnt_d;
      sda_fcnt_q  <= sda_fcnt_d;
      scl_filt_q  <= scl_filt_d;
      sda_filt_q  <= sda_filt_d;
      scl_prev_q  <= scl_prev_d;
      sda_prev_q  <= sda_prev_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      bit_q       <= bit_d;
      last_word_q <= last_word_d;
    end
  end

  // ---------------- decoder FSM ----------------
  state_t      state_q, state_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic        first_q, first_d;
  logic        pend_q, pend_d;
  logic [7:0]  byte_q, byte_d;
  logic [3:0]  frame_cnt;
  logic        push;
  logic [10:0] push_data;
  logic        ferr_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      first_q  <= 1'b0;
      pend_q   <= 1'b0;
      byte_q   <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      first_q  <= first_d;
      pend_q   <= pend_d;
      byte_q   <= byte_d;
    end
  end

  // pend marks a bit whose SCL pulse is still high; a START/STOP in that pulse
  // shows the pulse carried the condition, so that bit is not reported as data.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    first_d  = first_q;
    pend_d   = pend_q;
    byte_d   = byte_q;
    unique case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d  = RECV;
          bitcnt_d = '0;
          first_d  = 1'b1;
          pend_d   = 1'b0;
        end
      end
      RECV: begin
        if (start_q) begin
          bitcnt_d = '0;
          first_d  = 1'b1;
          pend_d   = 1'b0;
        end else if (stop_q) begin
          state_d  = IDLE;
          bitcnt_d = '0;
          pend_d   = 1'b0;
        end else if (rise_q) begin
          if (bitcnt_q == 4'd8) begin
            bitcnt_d = '0;
            first_d  = 1'b0;
            pend_d   = 1'b0;
          end else begin
            byte_d   = {byte_q[6:0], bit_q};
            bitcnt_d = bitcnt_q + 4'd1;
            pend_d   = 1'b1;
          end
        end else if (fall_q) begin
          pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_cnt = bitcnt_q - 4'(pend_q);
    push      = 1'b0;
    push_data = '0;
    ferr_set  = 1'b0;
    bus_busy  = (state_q == RECV);
    if (state_q == RECV) begin
      if (start_q) begin
        if (frame_cnt != 4'd0) begin
          push      = 1'b1;
          push_data = {2'b10, 1'b0, 4'h0, frame_cnt};
          ferr_set  = 1'b1;
        end
      end else if (stop_q) begin
        push      = 1'b1;
        push_data = {2'b10, 1'b0, 4'h0, frame_cnt};
        ferr_set  = (frame_cnt != 4'd0);
      end else if (rise_q && bitcnt_q == 4'd8) begin
        push      = 1'b1;
        push_data = {(first_q ? 2'b01 : 2'b00), bit_q, byte_q};
      end
    end
  end

  // ---------------- event FIFO + sticky flags ----------------
  logic [10:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic          full, pop, wr_en;

  always_comb begin
    full     = (count_q == CW'(FIFO_DEPTH));
    pop      = ev.m_valid && ev.m_ready;
    wr_en    = push && (!full || pop);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    overflow_d  = (push && full && !pop) | (overflow_q & ~clr_err);
    frame_err_d = ferr_set | (frame_err_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    ev.m_valid = (count_q != '0);
    ev.m_data  = ev.m_valid ? mem_q[rd_ptr_q] : '0;
    fifo_level = count_q;
    last_word  = last_word_q;
    overflow   = overflow_q;
    frame_err  = frame_err_q;
  end

endmodule

// File: tb/tb_sccb_bus_sniffer.sv
// Bus-level stimulus for sccb_bus_sniffer with a transaction-level model feeding a scoreboard
// queue; a separate monitor pops and compares every entry the DUT hands out.
module tb_sccb_bus_sniffer;
  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, scl, sda, clr_err;
  logic [4:0]  fifo_level;
  logic [31:0] last_word;
  logic        bus_busy, overflow, frame_err;

  sccb_bus_sniffer_if ev();

  sccb_bus_sniffer #(
    .SYNC_STAGES(2),
    .FILT_LEN   (4),
    .FIFO_DEPTH (DEPTH),
    .SHIFT_W    (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda),
    .ev        (ev),
    .fifo_level(fifo_level),
    .last_word (last_word),
    .bus_busy  (bus_busy),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          qp = 12;
  logic [10:0] exp_q[$];
  bit          cur_bits[$];
  bit          in_frame = 0, first_byte = 0;
  bit          exp_ovf = 0, exp_ferr = 0, exp_busy = 0;
  logic [31:0] lw_model = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic void exp_push(input logic [10:0] e, input bit concurrent_pop);
    if (exp_q.size() >= DEPTH && !concurrent_pop) exp_ovf = 1'b1;
    else exp_q.push_back(e);
  endfunction

  function automatic void model_start();
    if (in_frame && cur_bits.size() != 0) begin
      exp_push({2'b10, 1'b0, 4'h0, 4'(cur_bits.size())}, 1'b0);
      exp_ferr = 1'b1;
    end
    in_frame   = 1'b1;
    first_byte = 1'b1;
    exp_busy   = 1'b1;
    cur_bits.delete();
  endfunction

  function automatic void model_stop();
    if (in_frame) begin
      exp_push({2'b10, 1'b0, 4'h0, 4'(cur_bits.size())}, 1'b0);
      if (cur_bits.size() != 0) exp_ferr = 1'b1;
    end
    in_frame = 1'b0;
    exp_busy = 1'b0;
    cur_bits.delete();
  endfunction

  // monitor: compares whatever the DUT hands over against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && ev.m_valid && ev.m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_entry actual=0x%0h expected=none", ev.m_data);
        end else begin
          check("entry", ev.m_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // pulse: 0 none, 1 one-cycle m_ready aligned with the push, 2 clr_err aligned with the push,
  // 3 short SDA glitch while SCL is high
  task automatic bus_bit(input bit b, input int pulse);
    logic [7:0] v;
    int gw;
    gw  = $urandom_range(1, 3);
    sda = b;
    clks(qp);
    scl = 1'b1;
    lw_model = {lw_model[30:0], b};
    if (in_frame) begin
      cur_bits.push_back(b);
      if (cur_bits.size() == 9) begin
        v = '0;
        for (int i = 0; i < 8; i++) v = {v[6:0], cur_bits[i]};
        exp_push({(first_byte ? 2'b01 : 2'b00), b, v}, pulse == 1);
        if (pulse == 2) exp_ferr = 1'b0;
        first_byte = 1'b0;
        cur_bits.delete();
      end
    end
    for (int i = 1; i <= 2 * qp; i++) begin
      @(negedge clk);
      if (pulse == 1 && i == 7) ev.m_ready = 1'b1;
      if (pulse == 1 && i == 8) ev.m_ready = 1'b0;
      if (pulse == 2 && i == 7) clr_err = 1'b1;
      if (pulse == 2 && i == 8) clr_err = 1'b0;
      if (pulse == 3 && i == qp) sda = ~b;
      if (pulse == 3 && i == qp + gw) sda = b;
    end
    scl = 1'b0;
    clks(qp);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit ack, input int ack_pulse);
    for (int i = 7; i >= 0; i--) bus_bit(v[i], 0);
    bus_bit(ack, ack_pulse);
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      sda = 1'b1;
      clks(qp);
      scl = 1'b1;
      lw_model = {lw_model[30:0], 1'b1};
    end
    clks(qp);
    sda = 1'b0;
    model_start();
    clks(qp);
    scl = 1'b0;
    clks(qp);
  endtask

  task automatic bus_stop();
    sda = 1'b0;
    clks(qp);
    scl = 1'b1;
    lw_model = {lw_model[30:0], 1'b0};
    clks(qp);
    sda = 1'b1;
    model_stop();
    clks(2 * qp);
  endtask

  task automatic check_flags(input string tag);
    clks(12);
    check({tag, "_busy"}, bus_busy, exp_busy);
    check({tag, "_overflow"}, overflow, exp_ovf);
    check({tag, "_frame_err"}, frame_err, exp_ferr);
    check({tag, "_level"}, fifo_level, exp_q.size());
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    clks(1);
    clr_err = 1'b0;
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) clks(1);
    check({tag, "_pending"}, exp_q.size(), 0);
    clks(2);
    check({tag, "_level"}, fifo_level, 0);
  endtask

  initial begin
    int k;
    rst = 1'b1; scl = 1'b1; sda = 1'b1; clr_err = 1'b0; ev.m_ready = 1'b1;
    clks(3);
    check("rst_valid", ev.m_valid, 0);
    check("rst_data", ev.m_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_last_word", last_word, 0);
    check("rst_busy", bus_busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    clks(5);

    // write of three bytes at 100 kHz SCL on a 100 MHz clock
    qp = 250;
    bus_start();
    check_flags("t1_start");
    send_byte(8'h42, 1'b0, 0);
    send_byte(8'h0A, 1'b0, 0);
    send_byte(8'h1C, 1'b1, 0);
    bus_stop();
    qp = 12;
    check_flags("t1_end");
    check("t1_last_word", last_word, lw_model);

    // sub-filter-length SDA glitches, idle and inside a byte
    for (int g = 0; g < 3; g++) begin
      sda = 1'b0;
      clks($urandom_range(1, 3));
      sda = 1'b1;
      clks(20);
    end
    check_flags("t2_idle");
    bus_start();
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom_range(0, 1)), 3);
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom_range(0, 1)), 0);
    bus_bit(1'b0, 3);
    check_flags("t2_recv");
    bus_stop();

    // repeated START after a partial byte
    for (int r = 0; r < 2; r++) begin
      bus_start();
      send_byte(8'($urandom), 1'($urandom_range(0, 1)), 0);
      k = $urandom_range(1, 7);
      for (int i = 0; i < k; i++) bus_bit(1'($urandom_range(0, 1)), 0);
      bus_start();
      send_byte(8'($urandom), 1'b0, 0);
      bus_stop();
      check_flags("t3_err");
      pulse_clr();
      check_flags("t3_clr");
    end

    // overflow with consumer stalled
    ev.m_ready = 1'b0;
    bus_start();
    for (int i = 0; i < 17; i++) send_byte(8'($urandom), 1'($urandom_range(0, 1)), 0);
    check_flags("t4_full");
    check("t4_level16", fifo_level, DEPTH);
    ev.m_ready = 1'b1;
    wait_drain("t4_drain");
    bus_stop();
    wait_drain("t4_stop");
    pulse_clr();
    check_flags("t4_clr");

    // full FIFO: push+pop in one cycle, then clear racing a new overflow
    bus_start();
    bus_bit(1'b1, 0);
    bus_bit(1'b0, 0);
    bus_start();
    ev.m_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'($urandom_range(0, 1)), 0);
    check_flags("t5_full");
    send_byte(8'($urandom), 1'b0, 1);
    check_flags("t5_pushpop");
    pulse_clr();
    check_flags("t5_clr");
    send_byte(8'($urandom), 1'b1, 2);
    check_flags("t5_setwins");
    ev.m_ready = 1'b1;
    wait_drain("t5_drain");
    bus_stop();
    wait_drain("t5_stop");
    pulse_clr();

    // reset mid-byte, then a fresh transfer
    bus_start();
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom_range(0, 1)), 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    cur_bits.delete();
    in_frame = 1'b0; exp_busy = 1'b0; exp_ovf = 1'b0; exp_ferr = 1'b0;
    lw_model = '0;
    #1;
    check("t6_rst_valid", ev.m_valid, 0);
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_last_word", last_word, 0);
    check("t6_rst_busy", bus_busy, 0);
    clks(3);
    rst = 1'b0;
    clks(10);
    for (int i = 0; i < 5; i++) bus_bit(1'($urandom_range(0, 1)), 0);
    bus_stop();
    check_flags("t6_idle");
    bus_start();
    send_byte(8'hA5, 1'b0, 0);
    check_flags("t6_byte");
    begin
      logic [8:0] lw_low;
      lw_low = last_word[8:0];
      check("t6_last_word_lsb", lw_low, 9'h14A);
    end
    check("t6_last_word", last_word, lw_model);
    bus_stop();
    wait_drain("t6_end");
    check_flags("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
